coreahblsram_req_arbiter: RTL and testbench
===========================================

# coreahblsram_req_arbiter

Two-port request arbiter in front of the CoreAHBLSRAM SRAM control interface. It lets two masters share one SRAM controller, e.g. the AHB-Lite slave path and the UART bootloader image-load path. Each master issues single-beat read/write commands. The arbiter picks one master, replays its command to the controller as a one-cycle `ahbsram_req` pulse, and returns ack/error and read data. A watchdog stops a missing controller ack from hanging a master.

## Interface
- `MEM_AWIDTH`, 19: byte-address width of all address buses.
- `PRIORITY_MODE`, 0: 0 = round-robin; 1 = fixed priority, port 0 wins.
- `ACK_TIMEOUT`, 15: WAIT cycles without `sramahb_ack` before an error completion; legal range 2..255.

Ports:
- `HCLK` in 1: single clock, rising edge.
- `HRESETN` in 1: reset, asynchronous, active-low.
- `m0_req`, `m1_req` in 1: command request, level; held with its command fields until that port's ack.
- `m0_write`, `m1_write` in 1: 1 = write, 0 = read.
- `m0_size`, `m1_size` in 3: HSIZE encoding (000 byte, 001 half, 010 word).
- `m0_addr`, `m1_addr` in MEM_AWIDTH: byte address.
- `m0_wdata`, `m1_wdata` in 32: write data.
- `m0_ack`, `m1_ack` out 1: one-cycle completion pulse.
- `m0_err`, `m1_err` out 1: high with ack when the access timed out.
- `m_rdata` out 32: read data, shared; valid only in a read ack cycle.
- `ahbsram_req` out 1: one-cycle request pulse to the controller.
- `ahbsram_write` out 1: latched command field to the controller.
- `ahbsram_size` out 3: latched command field to the controller.
- `ahbsram_addr` out MEM_AWIDTH: latched command field to the controller.
- `ahbsram_wdata` out 32: latched command field to the controller.
- `sramahb_ack` in 1: controller completion pulse.
- `sramahb_rdata` in 32: controller read data, registered inside the controller.
- `BUSY` in 1: controller busy; no new grant while high.
- `gnt_id` out 1: port that owns the current or last transfer.
- `arb_active` out 1: high in any state other than IDLE.

## Operation
- States: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - If `BUSY`=0 and any request is high, select a winner, latch its write/size/addr/wdata into command registers, set `gnt_id`, and go to ISSUE.
  - Otherwise stay in IDLE.
- ISSUE:
  - `ahbsram_req`=1 for exactly this cycle; command outputs come from the registers.
  - Clear the timeout counter and go to WAIT.
- WAIT:
  - Command outputs stay stable and `ahbsram_req`=0.
  - If `sramahb_ack`=1, go to DONE with err_flag=0.
  - Else if counter = ACK_TIMEOUT-1, go to DONE with err_flag=1.
  - Else increment the counter (8-bit, saturating).
- DONE:
  - Assert ack for the `gnt_id` port; assert its err when err_flag=1.
  - `m_rdata` = `sramahb_rdata` when the command was a read and err_flag=0; otherwise 0.
  - Go to IDLE.
- Arbitration, `PRIORITY_MODE`=0:
  - Register `last_gnt` is updated on every grant; its reset value is 1, so port 0 wins the first contention.
  - With both requests high, the grant goes to the port != `last_gnt`.
  - With one request high, that port is granted.
- Arbitration, `PRIORITY_MODE`=1: port 0 wins whenever `m0_req`=1.
- A port's request in its own DONE cycle is ignored: the FSM is not in IDLE.
- The arbiter does not modify the command. Byte-lane enables and address alignment belong to the controller.

## Timing
- Reset values: all outputs 0, state IDLE, command registers 0, `last_gnt`=1, counter 0.
- Asserting `HRESETN` mid-transfer aborts it: no ack and no err are produced, and a late `sramahb_ack` arriving in IDLE is ignored.
- Nominal access, with T0 = the IDLE cycle in which the request is sampled:
  - T1: `ahbsram_req` pulse.
  - T2: `sramahb_ack`.
  - T3: port ack (with `m_rdata` for reads).
  - T4: earliest next grant.
  - Throughput is 4 cycles per access.
- Masters drop their request on the clock edge that ends the ack cycle, so the request is low in T4.
- Timeout: with no `sramahb_ack`, err+ack reach the master ACK_TIMEOUT+2 cycles after the grant.
- `BUSY` is sampled only in IDLE; it has no effect once ISSUE is entered.

## Test plan
- Single write, then read: m0 writes addr 0x00010, word 0xA5A5_1234; m0 reads back. Each ack comes 3 cycles after the request is sampled; the read returns `m_rdata`=0xA5A5_1234 with `m0_err`=0.
- Contention in round-robin mode: m0 and m1 both hold requests for 4 accesses. Grants alternate 0,1,0,1, starting with 0 after reset, and ack pulses are spaced 4 cycles apart.
- Fixed priority: `PRIORITY_MODE`=1, m0 requests continuously and m1 requests once. m1 is never granted until m0 drops its request, then m1 is granted on the next IDLE.
- Timeout: the controller model never acks, ACK_TIMEOUT=15. `m1_ack` and `m1_err` pulse together 17 cycles after the grant; `m_rdata`=0; the next request is then serviced normally.
- BUSY hold-off: `BUSY`=1 for 10 cycles while m0 requests. No `ahbsram_req` pulse appears. The grant comes the first cycle after `BUSY` falls, and `arb_active` stays 0 during the hold-off.
- Reset mid-WAIT: drive `HRESETN` low in WAIT. All outputs go to 0 immediately, and no ack follows release. A stale `sramahb_ack` one cycle after release produces no port ack.

Source files
------------

// File: rtl/coreahblsram_req_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : coreahblsram_req_arbiter_if
// Description : Signal bundle for the two-port CoreAHBLSRAM request arbiter:
//               both master command ports, the shared read-data return, the
//               controller command/ack path and arbiter status.
// Revision    : 1.0 - initial release
// ============================================================================
interface coreahblsram_req_arbiter_if #(
  parameter int MEM_AWIDTH = 19
);
  // Master command ports
  logic                  m0_req;
  logic                  m1_req;
  logic                  m0_write;
  logic                  m1_write;
  logic [2:0]            m0_size;
  logic [2:0]            m1_size;
  logic [MEM_AWIDTH-1:0] m0_addr;
  logic [MEM_AWIDTH-1:0] m1_addr;
  logic [31:0]           m0_wdata;
  logic [31:0]           m1_wdata;
  logic                  m0_ack;
  logic                  m1_ack;
  logic                  m0_err;
  logic                  m1_err;
  logic [31:0]           m_rdata;

  // Controller command path
  logic                  ahbsram_req;
  logic                  ahbsram_write;
  logic [2:0]            ahbsram_size;
  logic [MEM_AWIDTH-1:0] ahbsram_addr;
  logic [31:0]           ahbsram_wdata;
  logic                  sramahb_ack;
  logic [31:0]           sramahb_rdata;
  logic                  BUSY;

  // Status
  logic                  gnt_id;
  logic                  arb_active;

  // Arbiter side: serves the masters, drives the controller
  modport slave (
    input  m0_req, m1_req, m0_write, m1_write, m0_size, m1_size,
           m0_addr, m1_addr, m0_wdata, m1_wdata,
           sramahb_ack, sramahb_rdata, BUSY,
    output m0_ack, m1_ack, m0_err, m1_err, m_rdata,
           ahbsram_req, ahbsram_write, ahbsram_size, ahbsram_addr, ahbsram_wdata,
           gnt_id, arb_active
  );

  // Environment side: the masters plus the SRAM controller
  modport master (
    output m0_req, m1_req, m0_write, m1_write, m0_size, m1_size,
           m0_addr, m1_addr, m0_wdata, m1_wdata,
           sramahb_ack, sramahb_rdata, BUSY,
    input  m0_ack, m1_ack, m0_err, m1_err, m_rdata,
           ahbsram_req, ahbsram_write, ahbsram_size, ahbsram_addr, ahbsram_wdata,
           gnt_id, arb_active
  );
endinterface
`default_nettype wire

// File: rtl/coreahblsram_req_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : coreahblsram_req_arbiter
// Description : Two-port request arbiter in front of the CoreAHBLSRAM control
//               interface. Latches the winning command, issues a one-cycle
//               request to the controller, waits for its ack (with a
//               watchdog) and returns ack/err/read data to the granted port.
// Revision    : 1.0 - initial release
// ============================================================================
module coreahblsram_req_arbiter #(
  parameter int MEM_AWIDTH    = 19,
  parameter int PRIORITY_MODE = 0,   // 0 = round-robin, 1 = port 0 fixed priority
  parameter int ACK_TIMEOUT   = 15   // legal range 2..255
) (
  input  wire logic                  HCLK,
  input  wire logic                  HRESETN,
  coreahblsram_req_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Last counter value before the watchdog fires
  localparam logic [7:0] C_TMO_LAST = 8'(ACK_TIMEOUT - 1);

  state_t                state_q, state_d;
  logic                  write_q, write_d;
  logic [2:0]            size_q, size_d;
  logic [MEM_AWIDTH-1:0] addr_q, addr_d;
  logic [31:0]           wdata_q, wdata_d;
  logic                  gnt_id_q, gnt_id_d;
  logic                  last_gnt_q, last_gnt_d;
  logic [7:0]            cnt_q, cnt_d;
  logic                  err_q, err_d;

  // Port chosen if a grant happens this cycle (0 = m0, 1 = m1)
  logic                  win_sel;

  generate
    if (PRIORITY_MODE == 1) begin : g_fixed
      // Port 0 wins whenever it requests
      assign win_sel = ~bus.m0_req;
    end else begin : g_rr
      // On contention the port that did not win last time is served
      assign win_sel = (bus.m0_req && bus.m1_req) ? ~last_gnt_q : bus.m1_req;
    end
  endgenerate

  // State and command registers; reset aborts any transfer in flight
  always_ff @(posedge HCLK or negedge HRESETN) begin
    if (!HRESETN) begin
      state_q    <= ST_IDLE;
      write_q    <= 1'b0;
      size_q     <= 3'd0;
      addr_q     <= '0;
      wdata_q    <= 32'd0;
      gnt_id_q   <= 1'b0;
      last_gnt_q <= 1'b1;
      cnt_q      <= 8'd0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      write_q    <= write_d;
      size_q     <= size_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      gnt_id_q   <= gnt_id_d;
      last_gnt_q <= last_gnt_d;
      cnt_q      <= cnt_d;
      err_q      <= err_d;
    end
  end

  // Next-state logic: grant, issue, wait for ack or timeout, complete
  always_comb begin
    state_d    = state_q;
    write_d    = write_q;
    size_d     = size_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    gnt_id_d   = gnt_id_q;
    last_gnt_d = last_gnt_q;
    cnt_d      = cnt_q;
    err_d      = err_q;

    case (state_q)
      ST_IDLE: begin
        // BUSY only gates the grant decision; it is ignored once issued
        if (!bus.BUSY && (bus.m0_req || bus.m1_req)) begin
          gnt_id_d   = win_sel;
          last_gnt_d = win_sel;
          write_d    = win_sel ? bus.m1_write : bus.m0_write;
          size_d     = win_sel ? bus.m1_size  : bus.m0_size;
          addr_d     = win_sel ? bus.m1_addr  : bus.m0_addr;
          wdata_d    = win_sel ? bus.m1_wdata : bus.m0_wdata;
          state_d    = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        cnt_d   = 8'd0;
        err_d   = 1'b0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (bus.sramahb_ack) begin
          err_d   = 1'b0;
          state_d = ST_DONE;
        end else if (cnt_q == C_TMO_LAST) begin
          err_d   = 1'b1;
          state_d = ST_DONE;
        end else if (cnt_q != 8'hFF) begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Outputs decode from state so reset clears them immediately
  assign bus.ahbsram_req   = (state_q == ST_ISSUE);
  assign bus.ahbsram_write = write_q;
  assign bus.ahbsram_size  = size_q;
  assign bus.ahbsram_addr  = addr_q;
  assign bus.ahbsram_wdata = wdata_q;
  assign bus.gnt_id        = gnt_id_q;
  assign bus.arb_active    = (state_q != ST_IDLE);
  assign bus.m0_ack        = (state_q == ST_DONE) && !gnt_id_q;
  assign bus.m1_ack        = (state_q == ST_DONE) &&  gnt_id_q;
  assign bus.m0_err        = bus.m0_ack && err_q;
  assign bus.m1_err        = bus.m1_ack && err_q;
  // Read data is only meaningful for a read that completed normally
  assign bus.m_rdata       = ((state_q == ST_DONE) && !write_q && !err_q) ?
                             bus.sramahb_rdata : 32'd0;

endmodule
`default_nettype wire

// File: tb/tb_coreahblsram_req_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_coreahblsram_req_arbiter
// Description : Self-checking bench for coreahblsram_req_arbiter with a
//               behavioural SRAM controller and an expected-completion queue.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_coreahblsram_req_arbiter;

  localparam int AW  = 19;
  localparam int TMO = 15;

  logic HCLK    = 1'b0;
  logic HRESETN = 1'b0;
  always #5 HCLK = ~HCLK;

  int cyc = 0;
  always @(posedge HCLK) cyc <= cyc + 1;

  coreahblsram_req_arbiter_if #(.MEM_AWIDTH(AW)) bus    ();
  coreahblsram_req_arbiter_if #(.MEM_AWIDTH(AW)) bus_fp ();

  coreahblsram_req_arbiter #(.MEM_AWIDTH(AW), .PRIORITY_MODE(0), .ACK_TIMEOUT(TMO)) dut (
    .HCLK(HCLK), .HRESETN(HRESETN), .bus(bus)
  );

  coreahblsram_req_arbiter #(.MEM_AWIDTH(AW), .PRIORITY_MODE(1), .ACK_TIMEOUT(TMO)) dut_fp (
    .HCLK(HCLK), .HRESETN(HRESETN), .bus(bus_fp)
  );

  // Controller model for the round-robin instance: registered ack/rdata
  logic        ctl_noack     = 1'b0;
  logic        ctl_force_ack = 1'b0;
  logic [31:0] mem [0:255];
  always @(posedge HCLK) begin
    bus.sramahb_ack <= (bus.ahbsram_req && !ctl_noack) || ctl_force_ack;
    if (bus.ahbsram_req) begin
      if (bus.ahbsram_write) mem[bus.ahbsram_addr[9:2]] <= bus.ahbsram_wdata;
      else                   bus.sramahb_rdata <= mem[bus.ahbsram_addr[9:2]];
    end
  end

  // Controller model for the fixed-priority instance: always acks
  always @(posedge HCLK) begin
    bus_fp.sramahb_ack   <= bus_fp.ahbsram_req;
    bus_fp.sramahb_rdata <= 32'd0;
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  typedef struct {
    logic        port;
    logic        err;
    logic [31:0] rdata;
  } exp_t;

  exp_t exp_q[$];
  int   ack_cyc_q[$];
  int   ack_cnt = 0;
  exp_t exp_mon;

  task automatic push_exp(input logic p, input logic e, input logic [31:0] rd);
    exp_t x;
    x.port  = p;
    x.err   = e;
    x.rdata = rd;
    exp_q.push_back(x);
  endtask

  // Completion monitor: every port ack pops one expectation
  always @(negedge HCLK) begin
    if (bus.m0_ack || bus.m1_ack) begin
      ack_cnt++;
      ack_cyc_q.push_back(cyc);
      if (exp_q.size() == 0) begin
        check_val("unexpected_ack", {62'd0, bus.m1_ack, bus.m0_ack}, 64'd0);
      end else begin
        exp_mon = exp_q.pop_front();
        check_val("ack_port", bus.m1_ack, exp_mon.port);
        check_val("ack_single", bus.m0_ack & bus.m1_ack, 1'b0);
        check_val("ack_err", exp_mon.port ? bus.m1_err : bus.m0_err, exp_mon.err);
        check_val("ack_rdata", bus.m_rdata, exp_mon.rdata);
      end
    end
  end

  task automatic wait_ack(input bit port, output int c);
    c = -1;
    for (int i = 0; i < 60; i++) begin
      @(negedge HCLK);
      if ((port ? bus.m1_ack : bus.m0_ack) === 1'b1) begin
        c = cyc;
        break;
      end
    end
    if (c < 0) check_val(port ? "ack_wait_m1" : "ack_wait_m0", 64'd0, 64'd1);
  endtask

  // Called #1 after a rising edge; returns ack cycle minus sample cycle
  task automatic do_access(input bit port, input bit wr, input logic [AW-1:0] addr,
                           input logic [31:0] wd, input bit push, input bit exp_err,
                           input logic [31:0] exp_rd, output int lat);
    int c0, ca;
    if (push) push_exp(port, exp_err, exp_rd);
    if (port) begin
      bus.m1_write = wr; bus.m1_size = 3'b010; bus.m1_addr = addr; bus.m1_wdata = wd;
      bus.m1_req   = 1'b1;
    end else begin
      bus.m0_write = wr; bus.m0_size = 3'b010; bus.m0_addr = addr; bus.m0_wdata = wd;
      bus.m0_req   = 1'b1;
    end
    c0 = cyc;
    wait_ack(port, ca);
    lat = ca - c0;
    @(posedge HCLK); #1;
    if (port) bus.m1_req = 1'b0;
    else      bus.m0_req = 1'b0;
  endtask

  initial begin
    int lat, lat0, lat1, c, c0, a0, a1, fp_m0, fp_m1;
    bus.m0_req = 0; bus.m0_write = 0; bus.m0_size = 0; bus.m0_addr = 0; bus.m0_wdata = 0;
    bus.m1_req = 0; bus.m1_write = 0; bus.m1_size = 0; bus.m1_addr = 0; bus.m1_wdata = 0;
    bus.BUSY = 0;
    bus_fp.m0_req = 0; bus_fp.m0_write = 0; bus_fp.m0_size = 0; bus_fp.m0_addr = 0; bus_fp.m0_wdata = 0;
    bus_fp.m1_req = 0; bus_fp.m1_write = 0; bus_fp.m1_size = 0; bus_fp.m1_addr = 0; bus_fp.m1_wdata = 0;
    bus_fp.BUSY = 0;

    repeat (3) @(posedge HCLK);
    #1;
    check_val("rst_arb_active", bus.arb_active, 1'b0);
    check_val("rst_ahbsram_req", bus.ahbsram_req, 1'b0);
    check_val("rst_gnt_id", bus.gnt_id, 1'b0);
    check_val("rst_acks", {bus.m0_ack, bus.m1_ack, bus.m0_err, bus.m1_err}, 4'd0);
    check_val("rst_cmd", {bus.ahbsram_write, bus.ahbsram_size, bus.ahbsram_addr, bus.ahbsram_wdata}, 64'd0);
    HRESETN = 1'b1;
    @(posedge HCLK); #1;

    // Round-robin contention: grants 0,1,0,1 with acks 4 cycles apart
    a0 = ack_cyc_q.size();
    push_exp(1'b0, 1'b0, 32'd0);
    push_exp(1'b1, 1'b0, 32'd0);
    push_exp(1'b0, 1'b0, 32'd0);
    push_exp(1'b1, 1'b0, 32'd0);
    fork
      begin
        do_access(1'b0, 1'b1, 19'h100, 32'h1111_0100, 1'b0, 1'b0, 32'd0, lat0);
        do_access(1'b0, 1'b1, 19'h108, 32'h1111_0108, 1'b0, 1'b0, 32'd0, lat0);
      end
      begin
        do_access(1'b1, 1'b1, 19'h200, 32'h2222_0200, 1'b0, 1'b0, 32'd0, lat1);
        do_access(1'b1, 1'b1, 19'h204, 32'h2222_0204, 1'b0, 1'b0, 32'd0, lat1);
      end
    join
    check_val("rr_ack_count", ack_cyc_q.size() - a0, 4);
    if (ack_cyc_q.size() >= a0 + 4) begin
      for (int i = 1; i < 4; i++)
        check_val("rr_ack_spacing", ack_cyc_q[a0+i] - ack_cyc_q[a0+i-1], 4);
    end
    check_val("rr_last_gnt_id", bus.gnt_id, 1'b1);

    // Single write then read on port 0
    do_access(1'b0, 1'b1, 19'h00010, 32'hA5A5_1234, 1'b1, 1'b0, 32'd0, lat);
    check_val("wr_latency", lat, 3);
    do_access(1'b0, 1'b0, 19'h00010, 32'd0, 1'b1, 1'b0, 32'hA5A5_1234, lat);
    check_val("rd_latency", lat, 3);
    do_access(1'b1, 1'b0, 19'h204, 32'd0, 1'b1, 1'b0, 32'h2222_0204, lat);
    check_val("rd_m1_latency", lat, 3);

    // Controller never acks: error completion ACK_TIMEOUT+2 cycles after grant
    ctl_noack = 1'b1;
    do_access(1'b1, 1'b0, 19'h00010, 32'd0, 1'b1, 1'b1, 32'd0, lat);
    check_val("tmo_latency", lat, TMO + 2);
    ctl_noack = 1'b0;
    do_access(1'b1, 1'b0, 19'h00010, 32'd0, 1'b1, 1'b0, 32'hA5A5_1234, lat);
    check_val("tmo_recover_latency", lat, 3);

    // BUSY hold-off
    bus.BUSY = 1'b1;
    push_exp(1'b0, 1'b0, 32'hA5A5_1234);
    bus.m0_write = 1'b0; bus.m0_size = 3'b010; bus.m0_addr = 19'h00010; bus.m0_req = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge HCLK);
      check_val("busy_no_req", bus.ahbsram_req, 1'b0);
      check_val("busy_idle", bus.arb_active, 1'b0);
    end
    @(posedge HCLK); #1;
    bus.BUSY = 1'b0;
    @(negedge HCLK);
    @(negedge HCLK);
    check_val("busy_release_req", bus.ahbsram_req, 1'b1);
    wait_ack(1'b0, c);
    @(posedge HCLK); #1;
    bus.m0_req = 1'b0;

    // Fixed priority: m0 continuous, m1 waits until m0 drops
    bus_fp.m0_write = 1'b1; bus_fp.m0_size = 3'b010; bus_fp.m0_addr = 19'h40; bus_fp.m0_wdata = 32'h4;
    bus_fp.m1_write = 1'b1; bus_fp.m1_size = 3'b010; bus_fp.m1_addr = 19'h80; bus_fp.m1_wdata = 32'h8;
    bus_fp.m0_req = 1'b1;
    bus_fp.m1_req = 1'b1;
    fp_m0 = 0;
    fp_m1 = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge HCLK);
      if (bus_fp.m0_ack) fp_m0++;
      if (bus_fp.m1_ack) fp_m1++;
    end
    check_val("fp_m0_acks", fp_m0, 4);
    check_val("fp_m1_starved", fp_m1, 0);
    @(posedge HCLK); #1;
    bus_fp.m0_req = 1'b0;
    c0 = cyc;
    c  = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge HCLK);
      if (bus_fp.m1_ack) begin
        c = cyc;
        break;
      end
    end
    check_val("fp_m1_latency", c - c0, 3);
    check_val("fp_m1_gnt_id", bus_fp.gnt_id, 1'b1);
    @(posedge HCLK); #1;
    bus_fp.m1_req = 1'b0;

    // Reset in WAIT aborts the transfer; a stale controller ack is ignored
    ctl_noack = 1'b1;
    bus.m1_write = 1'b0; bus.m1_size = 3'b010; bus.m1_addr = 19'h00010; bus.m1_req = 1'b1;
    @(negedge HCLK);
    @(negedge HCLK);
    check_val("rstw_issue", bus.ahbsram_req, 1'b1);
    @(negedge HCLK);
    check_val("rstw_in_wait", {bus.arb_active, bus.ahbsram_req}, 2'b10);
    a1 = ack_cnt;
    HRESETN = 1'b0;
    #1;
    check_val("rstw_arb_active", bus.arb_active, 1'b0);
    check_val("rstw_gnt_id", bus.gnt_id, 1'b0);
    check_val("rstw_cmd", {bus.ahbsram_req, bus.ahbsram_write, bus.ahbsram_size, bus.ahbsram_addr}, 64'd0);
    check_val("rstw_acks", {bus.m0_ack, bus.m1_ack, bus.m0_err, bus.m1_err, bus.m_rdata}, 64'd0);
    bus.m1_req = 1'b0;
    @(posedge HCLK); #1;
    HRESETN   = 1'b1;
    ctl_noack = 1'b0;
    @(posedge HCLK); #1;
    ctl_force_ack = 1'b1;
    @(posedge HCLK); #1;
    ctl_force_ack = 1'b0;
    repeat (6) @(negedge HCLK);
    check_val("rstw_no_ack", ack_cnt - a1, 0);
    check_val("rstw_idle", bus.arb_active, 1'b0);

    check_val("sb_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
